nonce_target_check: RTL

NONCE_TARGET_CHECK -- requirements
Module: nonce_target_check

---
 rtl/nonce_target_check.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/nonce_target_check.sv
// -----------------------------------------------------------------------------
// nonce_target_check
//
// Scans NUM_NONCES consecutive 32-bit H0 words from a shared single-port word
// memory (1-cycle read latency) and compares each against an unsigned
// difficulty target (strict less-than). Reports whether any nonce met the
// target, the lowest matching index and the number of matches. Optionally
// writes a packed result word back to memory.
//
// Optional feature macro: RESULT_WRITEBACK_EN
//   defined   : a one-cycle WRITE state stores
//               {found, 7'b0, match_count (8b), nonce_idx (16b)} at result_addr
//   undefined : no WRITE state, mem_we is tied low, result_addr is unused
//
// Ports
//   clk             in   rising-edge clock
//   reset_n         in   synchronous active-low reset
//   start           in   one-cycle scan request (honoured only in IDLE/DONE)
//   hash_addr       in   base word address of the H0 array
//   result_addr     in   word address of the result writeback
//   target          in   unsigned difficulty threshold
//   done            out  scan complete, held until the next accepted start
//   found           out  at least one nonce matched
//   nonce_idx       out  lowest matching index (0 when found=0)
//   match_count     out  number of matching nonces
//   mem_clk         out  memory clock (same as clk)
//   mem_we          out  memory write enable
//   mem_addr        out  memory word address
//   mem_write_data  out  memory write data
//   mem_read_data   in   memory read data (valid one cycle after mem_addr)
// -----------------------------------------------------------------------------
module nonce_target_check #(
    parameter int NUM_NONCES = 16,
    parameter int IDX_W      = $clog2(NUM_NONCES)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [15:0]      hash_addr,
    input  logic [15:0]      result_addr,
    input  logic [31:0]      target,
    output logic             done,
    output logic             found,
    output logic [IDX_W-1:0] nonce_idx,
    output logic [IDX_W:0]   match_count,
    output logic             mem_clk,
    output logic             mem_we,
    output logic [15:0]      mem_addr,
    output logic [31:0]      mem_write_data,
    input  logic [31:0]      mem_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
`ifdef RESULT_WRITEBACK_EN
        WRITE,
`endif
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NONCES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W:0]   CNT_ONE  = {{IDX_W{1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [31:0]      target_q, target_d;
    logic [IDX_W-1:0] rd_cnt_q, rd_cnt_d;     // index of the address being driven
    logic [IDX_W-1:0] cmp_idx_q, cmp_idx_d;   // index of the word being compared
    logic             cmp_pend_q, cmp_pend_d; // a read issued last cycle returns now
    logic             done_q, done_d;
    logic             found_q, found_d;
    logic [IDX_W-1:0] nonce_idx_q, nonce_idx_d;
    logic [IDX_W:0]   match_count_q, match_count_d;
    logic [15:0]      mem_addr_q, mem_addr_d;
    logic             hit;

`ifdef RESULT_WRITEBACK_EN
    logic [15:0]      result_q, result_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
`else
    logic             unused_result_addr;
    assign unused_result_addr = ^result_addr;
`endif

    assign mem_clk = clk;

    // Strict unsigned compare: a word equal to the target does not match.
    assign hit = cmp_pend_q && (mem_read_data < target_q);

    // NOTE: every variable gets its hold/default value first so no path through
    // the case statement can leave one unassigned (which would infer a latch).
    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        rd_cnt_d      = rd_cnt_q;
        cmp_idx_d     = cmp_idx_q;
        cmp_pend_d    = (state_q == READ);
        done_d        = done_q;
        found_d       = found_q;
        nonce_idx_d   = nonce_idx_q;
        match_count_d = match_count_q;
        mem_addr_d    = mem_addr_q;
`ifdef RESULT_WRITEBACK_EN
        result_d      = result_q;
        mem_we_d      = 1'b0;
        mem_wdata_d   = mem_wdata_q;
`endif

        // Compare stage: runs one cycle behind the address stage (READ/DRAIN).
        if (cmp_pend_q) begin
            cmp_idx_d = cmp_idx_q + IDX_ONE;
            if (hit) begin
                match_count_d = match_count_q + CNT_ONE;
                if (!found_q) begin
                    found_d     = 1'b1;
                    nonce_idx_d = cmp_idx_q;
                end
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    target_d      = target;
`ifdef RESULT_WRITEBACK_EN
                    result_d      = result_addr;
`endif
                    rd_cnt_d      = '0;
                    cmp_idx_d     = '0;
                    done_d        = 1'b0;
                    found_d       = 1'b0;
                    nonce_idx_d   = '0;
                    match_count_d = '0;
                    // The first read address is issued in the cycle after start.
                    mem_addr_d    = hash_addr;
                    state_d       = READ;
                end
            end

            READ: begin
                if (rd_cnt_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    rd_cnt_d   = rd_cnt_q + IDX_ONE;
                    // 16-bit add wraps naturally past 0xFFFF.
                    mem_addr_d = mem_addr_q + 16'd1;
                end
            end

            DRAIN: begin
`ifdef RESULT_WRITEBACK_EN
                // Pack the results including this cycle's final compare.
                state_d     = WRITE;
                mem_we_d    = 1'b1;
                mem_addr_d  = result_q;
                mem_wdata_d = {found_d, 7'b0, 8'(match_count_d), 16'(nonce_idx_d)};
`else
                state_d = DONE;
                done_d  = 1'b1;
`endif
            end

`ifdef RESULT_WRITEBACK_EN
            WRITE: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
`endif

            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is sampled on the clock edge only (synchronous); all state
    // updates use non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            target_q      <= '0;
            rd_cnt_q      <= '0;
            cmp_idx_q     <= '0;
            cmp_pend_q    <= 1'b0;
            done_q        <= 1'b0;
            found_q       <= 1'b0;
            nonce_idx_q   <= '0;
            match_count_q <= '0;
            mem_addr_q    <= '0;
`ifdef RESULT_WRITEBACK_EN
            result_q      <= '0;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            rd_cnt_q      <= rd_cnt_d;
            cmp_idx_q     <= cmp_idx_d;
            cmp_pend_q    <= cmp_pend_d;
            done_q        <= done_d;
            found_q       <= found_d;
            nonce_idx_q   <= nonce_idx_d;
            match_count_q <= match_count_d;
            mem_addr_q    <= mem_addr_d;
`ifdef RESULT_WRITEBACK_EN
            result_q      <= result_d;
            mem_we_q      <= mem_we_d;
            mem_wdata_q   <= mem_wdata_d;
`endif
        end
    end

    assign done        = done_q;
    assign found       = found_q;
    assign nonce_idx   = nonce_idx_q;
    assign match_count = match_count_q;
    assign mem_addr    = mem_addr_q;
`ifdef RESULT_WRITEBACK_EN
    assign mem_we         = mem_we_q;
    assign mem_write_data = mem_wdata_q;
`else
    assign mem_we         = 1'b0;
    assign mem_write_data = 32'd0;
`endif

endmodule
